paging_unit: RTL and testbench

Page-table address translator between the CPU core and the memory bus. Maps a 16-bit virtual address onto a 20-bit logical (physical) address through a 64-entry page table of 16-bit entries. The table is written by the core over a simple write port, and translation is combinational.

---
 rtl/paging_unit_pkg.sv | 25 ++
 rtl/paging_unit_page_table.sv | 28 ++
 rtl/paging_unit.sv | 36 +++
 tb/tb_paging_unit.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/paging_unit_pkg.sv
// Shared geometry and page-table entry layout for the paging unit.
package paging_unit_pkg;

    localparam int unsigned VADDR_W   = 16;
    localparam int unsigned LADDR_W   = 20;
    localparam int unsigned OFFSET_W  = 10;
    localparam int unsigned INDEX_W   = 6;
    localparam int unsigned FRAME_W   = 10;
    localparam int unsigned PTE_W     = 16;
    localparam int unsigned NUM_PAGES = 64;

    typedef struct packed {
        logic [5:0] reserved;
        logic [9:0] frame;
    } pte_t;

    // Reset content of a slot: each page maps onto the frame of the same number.
    function automatic pte_t identityPte(input logic [INDEX_W-1:0] idx);
        pte_t p;
        p.reserved = '0;
        p.frame    = {{(FRAME_W-INDEX_W){1'b0}}, idx};
        return p;
    endfunction

endpackage

// File: rtl/paging_unit_page_table.sv
// 64x16 page-table register file: one synchronous write port, one combinational read port.
module paging_unit_page_table
    import paging_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rstN,
    input  logic               wrEn,
    input  logic [INDEX_W-1:0] wrIndex,
    input  logic [PTE_W-1:0]   wrData,
    input  logic [INDEX_W-1:0] rdIndex,
    output pte_t               rdPte
);

    pte_t table_q [NUM_PAGES];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int unsigned i = 0; i < NUM_PAGES; i++) begin
                table_q[i] <= identityPte(i[INDEX_W-1:0]);
            end
        end else if (wrEn) begin
            table_q[wrIndex] <= pte_t'(wrData);
        end
    end

    assign rdPte = table_q[rdIndex];

endmodule

// File: rtl/paging_unit.sv
// Virtual-to-logical address translator: page index selects a table entry whose frame replaces it.
module paging_unit
    import paging_unit_pkg::*;
(
    input  logic               Clk,
    input  logic               Rst,
    input  logic               WE,
    input  logic [INDEX_W-1:0] WPTI,
    input  logic [PTE_W-1:0]   WPTE,
    input  logic [VADDR_W-1:0] VAddr,
    output logic [LADDR_W-1:0] LAddr
);

    logic [INDEX_W-1:0]  pageIndex;
    logic [OFFSET_W-1:0] pageOffset;
    pte_t                curPte;
    logic [5:0]          unusedReserved;

    assign pageIndex  = VAddr[VADDR_W-1:OFFSET_W];
    assign pageOffset = VAddr[OFFSET_W-1:0];

    paging_unit_page_table pageTable (
        .clk     (Clk),
        .rstN    (Rst),
        .wrEn    (WE),
        .wrIndex (WPTI),
        .wrData  (WPTE),
        .rdIndex (pageIndex),
        .rdPte   (curPte)
    );

    // Reserved PTE bits are kept in the table but play no part in translation.
    assign unusedReserved = curPte.reserved;
    assign LAddr          = {curPte.frame, pageOffset};

endmodule

// File: tb/tb_paging_unit.sv
// Directed self-checking bench for paging_unit with hand-computed translations.
module tb_paging_unit;

    logic        Clk;
    logic        Rst;
    logic        WE;
    logic [5:0]  WPTI;
    logic [15:0] WPTE;
    logic [15:0] VAddr;
    logic [19:0] LAddr;

    int unsigned nCompared   = 0;
    int unsigned nMismatched = 0;

    paging_unit dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .WE    (WE),
        .WPTI  (WPTI),
        .WPTE  (WPTE),
        .VAddr (VAddr),
        .LAddr (LAddr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic checkAddr(input string tag, input logic [15:0] va, input logic [19:0] expected);
        VAddr = va;
        #1;
        nCompared++;
        assert (LAddr === expected) else begin
            nMismatched++;
            $error("FAIL %s: VAddr=%h LAddr=%h expected %h", tag, va, LAddr, expected);
        end
    endtask

    task automatic writePte(input logic [5:0] idx, input logic [15:0] data);
        @(negedge Clk);
        WE   = 1'b1;
        WPTI = idx;
        WPTE = data;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        @(negedge Clk);
        WE = 1'b0;
    endtask

    initial begin
        Rst   = 1'b0;
        WE    = 1'b0;
        WPTI  = '0;
        WPTE  = '0;
        VAddr = '0;
        #12;
        checkAddr("reset_0x1234", 16'h1234, 20'h01234);
        checkAddr("reset_0xFFFF", 16'hFFFF, 20'h0FFFF);
        @(negedge Clk);
        Rst = 1'b1;

        // 1: identity map after release
        checkAddr("ident_0000", 16'h0000, 20'h00000);
        checkAddr("ident_0402", 16'h0402, 20'h00402);
        checkAddr("ident_FFFF", 16'hFFFF, 20'h0FFFF);

        // 2: swap pages 0 and 1
        writePte(6'd0, 16'h0001);
        writePte(6'd1, 16'h0000);
        idle();
        checkAddr("swap_p0", 16'h0002, 20'h00402);
        checkAddr("swap_p1", 16'h0402, 20'h00002);
        checkAddr("untouched_p2", 16'h0802, 20'h00802);

        // 3: top entry to top frame
        writePte(6'd63, 16'h03FF);
        idle();
        checkAddr("p63_FFFF", 16'hFFFF, 20'hFFFFF);
        checkAddr("p63_FC00", 16'hFC00, 20'hFFC00);

        // 4: reserved bits ignored
        writePte(6'd2, 16'hFC05);
        idle();
        checkAddr("reserved_ignored", 16'h0813, 20'h01413);

        // 5: WE=0 holds the table
        WPTI = 6'd3;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            WPTE = (k % 2 == 0) ? 16'h0123 : 16'h0321;
        end
        @(posedge Clk);
        #1;
        checkAddr("we0_hold", 16'h0C00, 20'h00C00);

        // back-to-back writes to one index: last wins
        writePte(6'd4, 16'h0011);
        writePte(6'd4, 16'h0022);
        idle();
        checkAddr("b2b_last_wins", 16'h1001, 20'h08801);

        // write to the page being translated: old before edge, new after
        @(negedge Clk);
        WE   = 1'b1;
        WPTI = 6'd7;
        WPTE = 16'h0200;
        checkAddr("pre_edge_old", 16'h1C07, 20'h01C07);
        @(posedge Clk);
        checkAddr("post_edge_new", 16'h1C07, 20'h80007);
        idle();

        // 6: asynchronous reset mid-cycle
        @(posedge Clk);
        #2;
        Rst = 1'b0;
        checkAddr("async_rst_p7", 16'h1C07, 20'h01C07);
        checkAddr("async_rst_p0", 16'h0002, 20'h00002);
        checkAddr("async_rst_p63", 16'hFFFF, 20'h0FFFF);
        @(negedge Clk);
        WE   = 1'b1;
        WPTI = 6'd5;
        WPTE = 16'h0155;
        @(posedge Clk);
        checkAddr("write_in_reset_dropped", 16'h1400, 20'h01400);
        @(negedge Clk);
        WE  = 1'b0;
        Rst = 1'b1;
        checkAddr("post_rst_p4", 16'h1001, 20'h01001);
        checkAddr("post_rst_p2", 16'h0813, 20'h00813);
        writePte(6'd5, 16'h0155);
        idle();
        checkAddr("first_write_after_rst", 16'h1400, 20'h55400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
